// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter that lets N_REQ requesters share
// a single FIFO write port. At most one requester is granted at a time.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_write,
  input  logic                          fifo_full,
  output logic [$clog2(N_REQ)-1:0]      owner,
  output logic                          busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int SW = PW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state;
  logic [PW-1:0]         owner_q;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         pick;
  logic [PW-1:0]         next_ptr;
  logic [SW-1:0]         slot;
  logic [BW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] words [N_REQ];
  logic                  granted;
  logic                  last_beat;
  logic                  release_now;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan downwards so the candidate closest to rr_ptr wins.
  always_comb begin
    pick = '0;
    slot = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      slot = {1'b0, rr_ptr} + SW'(k);
      if (slot >= SW'(N_REQ)) begin
        slot = slot - SW'(N_REQ);
      end
      if (req_valid[slot[PW-1:0]]) begin
        pick = slot[PW-1:0];
      end
    end
  end

  assign granted = (state == GRANT);
  assign busy    = granted;
  assign owner   = granted ? owner_q : '0;

  always_comb begin
    req_ready  = '0;
    fifo_write = 1'b0;
    fifo_din   = '0;
    if (granted) begin
      req_ready[owner_q] = !fifo_full;
      fifo_write         = req_valid[owner_q] & !fifo_full;
      fifo_din           = words[owner_q];
    end
  end

  assign last_beat   = (beat_cnt == BW'(MAX_BURST - 1));
  assign release_now = granted &&
                       (!req_valid[owner_q] ||
                        (fifo_write && last_beat));
  assign next_ptr    = (owner_q == PW'(N_REQ - 1)) ?
                       '0 : owner_q + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            state    <= GRANT;
            owner_q  <= pick;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (fifo_write) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
